// File: rtl/iob_pfsm_initiator.sv
// Single-outstanding IOb native-interface initiator: takes one command at a time,
// runs the IOb request/read-data handshake and reports completion or timeout.
module iob_pfsm_initiator #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_wstrb_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                busy_o,
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_ready_i
);

    // Handshakes: a command transfers on an edge where cmd_valid_i & cmd_ready_o;
    // an IOb request transfers on an edge where iob_avalid_o & iob_ready_i;
    // read data transfers on an edge where iob_rvalid_i is high in WAIT_RD.

    localparam int STRB_W = DATA_W / 8;
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        RSP     = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 accept;
    logic                 wr_done;
    logic                 rd_done;
    logic                 tmo;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        wr_done = 1'b0;
        rd_done = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A handshake on the same edge as the counter expiring completes normally.
                if (iob_ready_i) begin
                    if (|iob_wstrb_o) begin
                        wr_done = 1'b1;
                        state_d = RSP;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_d = RSP;
                end
            end
            WAIT_RD: begin
                if (iob_rvalid_i) begin
                    rd_done = 1'b1;
                    state_d = RSP;
                end else if (cnt_q == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_d = RSP;
                end
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            iob_addr_o  <= '0;
            iob_wdata_o <= '0;
            iob_wstrb_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                iob_addr_o  <= cmd_addr_i;
                iob_wdata_o <= cmd_wdata_i;
                iob_wstrb_o <= cmd_wstrb_i;
            end
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == REQ || state_q == WAIT_RD) begin
                cnt_q <= cnt_q + TIMEOUT_W'(1);
            end
            // Response fields only change on entry to RSP, so they hold between responses.
            if (wr_done) begin
                rsp_rdata_o <= '0;
                rsp_err_o   <= 1'b0;
            end
            if (rd_done) begin
                rsp_rdata_o <= iob_rdata_i;
                rsp_err_o   <= 1'b0;
            end
            if (tmo) begin
                rsp_rdata_o <= '0;
                rsp_err_o   <= 1'b1;
            end
        end
    end

    // cmd_ready_o is held low while reset is asserted so every output reads 0 in reset.
    assign cmd_ready_o  = rstn_i && (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign iob_avalid_o = (state_q == REQ);
    assign rsp_valid_o  = (state_q == RSP);

    logic unused_strb_w;
    assign unused_strb_w = (STRB_W == 0);

endmodule
